equiv_check_seq: RTL and testbench

- Hardware sequencer that drives one stimulus bus into a golden combinational module and its post-route netlist counterpart. Both modules share that bus, e.g. the and2 golden/post_route pair.
- Walks every input vector exhaustively, waits a settle window per vector, then compares the two output buses.
- Counts mismatches, latches the first failing vector and reports pass/fail on completion.
- Sits beside the golden/netlist pair in on-board or simulation equivalence harnesses; replaces the hand-written stimulus/compare tasks.

---
 rtl/equiv_check_seq.sv | 84 ++++++++
 tb/tb_equiv_check_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/equiv_check_seq.sv
// equiv_check_seq: walks every stimulus vector into a golden/netlist pair and compares their outputs.
// Counts mismatches with saturation, latches the first failing vector, and reports pass/fail in DONE.
module equiv_check_seq #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] golden_out,
    input  logic [N_OUT-1:0] netlist_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             first_fail_valid,
    output logic [N_IN-1:0]  first_fail_vec
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COMPARE, S_DONE} state_t;
    state_t state, nxt;
    logic [SW-1:0] settle_cnt;
    logic mm, idle_start;
    logic [CNT_W-1:0] cnt_nx;

    assign mm = golden_out != netlist_out;
    assign cnt_nx = (mm && !(&mismatch_count)) ? mismatch_count + 1'b1 : mismatch_count;
    assign idle_start = (state == S_IDLE || state == S_DONE) && start;
    assign busy = state == S_SETTLE || state == S_COMPARE;
    assign done = state == S_DONE;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE: nxt = start ? S_SETTLE : state;
            S_SETTLE:       nxt = abort ? S_IDLE : (settle_cnt == '0) ? S_COMPARE : S_SETTLE;
            S_COMPARE:      nxt = abort ? S_IDLE : (&stim) ? S_DONE : S_SETTLE;
            default:        nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            stim             <= '0;
            pass             <= 1'b0;
            mismatch_count   <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            settle_cnt       <= '0;
        end else begin
            state <= nxt;
            if (idle_start) begin
                stim             <= '0;
                pass             <= 1'b0;
                mismatch_count   <= '0;
                first_fail_valid <= 1'b0;
                first_fail_vec   <= '0;
                settle_cnt       <= SETTLE_LD;
            end else if (state == S_SETTLE && !abort && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end else if (state == S_COMPARE && !abort) begin
                mismatch_count <= cnt_nx;
                if (mm && !first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= stim;
                end
                // the last vector ends the run, so stim never wraps
                if (&stim) begin
                    pass <= cnt_nx == '0;
                end else begin
                    stim       <= stim + 1'b1;
                    settle_cnt <= SETTLE_LD;
                end
            end
        end
    end
endmodule

// File: tb/tb_equiv_check_seq.sv
// tb_equiv_check_seq: drives and2 golden/netlist pairs (identical, stuck-at-0, inverted) through two DUT configs.
// Expected run results are queued at start and checked by a monitor when done rises.
module tb_equiv_check_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    int mode = 0;
    always #5 clk = ~clk;

    logic [1:0] s0, ffvec0;
    logic g0, n0, busy0, done0, pass0, ffv0;
    logic [7:0] mc0;
    assign g0 = s0[0] & s0[1];
    assign n0 = (mode == 0) ? g0 : (mode == 1) ? 1'b0 : ~g0;

    logic [2:0] s1, ffvec1;
    logic g1, n1, busy1, done1, pass1, ffv1;
    logic [1:0] mc1;
    assign g1 = s1[0] & s1[1];
    assign n1 = ~g1;

    equiv_check_seq #(.N_IN(2), .N_OUT(1), .SETTLE(1), .CNT_W(8)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .stim(s0),
        .golden_out(g0), .netlist_out(n0), .busy(busy0), .done(done0), .pass(pass0),
        .mismatch_count(mc0), .first_fail_valid(ffv0), .first_fail_vec(ffvec0));

    equiv_check_seq #(.N_IN(3), .N_OUT(1), .SETTLE(1), .CNT_W(2)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .stim(s1),
        .golden_out(g1), .netlist_out(n1), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_count(mc1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1));

    typedef struct {int id; int cnt; bit ffv; int vec; bit ps;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_res(int id, int cnt, bit ffv, int vec, bit ps);
        exp_t e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: dut %0d finished with no run queued", id);
        end else begin
            e = q.pop_front();
            chk("dut_id", id, e.id);
            chk("mismatch_count", cnt, e.cnt);
            chk("first_fail_valid", ffv, e.ffv);
            chk("first_fail_vec", vec, e.vec);
            chk("pass", ps, e.ps);
        end
    endtask

    initial begin
        logic pd0, pd1;
        pd0 = 1'b0;
        pd1 = 1'b0;
        forever begin
            @(negedge clk);
            if (done0 && !pd0) check_res(0, mc0, ffv0, ffvec0, pass0);
            if (done1 && !pd1) check_res(1, mc1, ffv1, ffvec1, pass1);
            pd0 = done0;
            pd1 = done1;
        end
    end

    task automatic pulse0();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
    endtask

    task automatic run0(int m, bit sched, int cnt, bit ffv, int vec, bit ps);
        int k;
        exp_t e;
        mode = m;
        e = '{0, cnt, ffv, vec, ps};
        q.push_back(e);
        pulse0();
        k = 0;
        while (!done0 && k < 20) begin
            if (sched) begin
                chk("stim_step", s0, k / 2);
                chk("busy_run", busy0, 1);
            end
            @(negedge clk);
            k++;
        end
        chk("latency0", k, 8);
        if (sched) chk("stim_final", s0, 3);
    endtask

    initial begin
        int k;
        exp_t e;
        repeat (2) @(negedge clk);
        chk("rst_stim", s0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_count", mc0, 0);
        chk("rst_ffv", ffv0, 0);
        chk("rst_ffvec", ffvec0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run0(0, 1'b1, 0, 1'b0, 0, 1'b1);
        run0(1, 1'b0, 1, 1'b1, 3, 1'b0);
        run0(2, 1'b0, 4, 1'b1, 0, 1'b0);
        mode = 0;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        chk("restart_clears_count", mc0, 0);
        chk("restart_clears_done", done0, 0);
        chk("restart_clears_ffv", ffv0, 0);
        e = '{0, 0, 1'b0, 0, 1'b1};
        q.push_back(e);
        k = 0;
        while (!done0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("latency_restart", k, 8);

        e = '{1, 3, 1'b1, 0, 1'b0};
        q.push_back(e);
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        k = 0;
        while (!done1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("latency1", k, 16);

        mode = 0;
        pulse0();
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        chk("start_busy_ignored", s0, 1);
        repeat (2) @(negedge clk);
        chk("abort_pre_stim", s0, 2);
        chk("abort_pre_busy", busy0, 1);
        abort0 = 1'b1;
        @(negedge clk) abort0 = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_pass", pass0, 0);
        chk("abort_stim_kept", s0, 2);
        repeat (12) @(negedge clk);
        chk("abort_stays_idle", done0, 0);
        run0(0, 1'b0, 0, 1'b0, 0, 1'b1);

        mode = 2;
        pulse0();
        repeat (3) @(negedge clk);
        chk("pre_reset_count", mc0, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_stim", s0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_count", mc0, 0);
        chk("arst_ffv", ffv0, 0);
        chk("arst_ffvec", ffvec0, 0);
        chk("arst_done", done0, 0);
        @(negedge clk) rst_n = 1'b1;
        run0(0, 1'b1, 0, 1'b0, 0, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
